keypad_emulator: RTL and testbench

KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

---
 rtl/keypad_emulator.sv | 153 +++++++++++++++
 tb/tb_keypad_emulator.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_emulator.sv
// Emulates one key press on a 4x4 scanned matrix: bounce-in, clean hold, bounce-out, quiet gap (bounce phases only with KEYPAD_EMU_BOUNCE_EN).
// Latency: accept to key_ready = 2*BOUNCE+HOLD+GAP+1 cycles (HOLD+GAP+1 without bounce); col follows row combinationally.
// Backpressure: one request at a time; key_valid is ignored while busy and never queued.
module keypad_emulator #(
    parameter int HOLD_CYCLES   = 1000,
    parameter int BOUNCE_CYCLES = 64,
    parameter int GAP_CYCLES    = 1000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic       busy,
    output logic       done
);

    localparam logic [15:0] HOLD_LEN   = (HOLD_CYCLES   == 0) ? 16'd1 : 16'(HOLD_CYCLES);
    localparam logic [15:0] BOUNCE_LEN = (BOUNCE_CYCLES == 0) ? 16'd1 : 16'(BOUNCE_CYCLES);
    localparam logic [15:0] GAP_LEN    = (GAP_CYCLES    == 0) ? 16'd1 : 16'(GAP_CYCLES);

    // Key at (r,c) sits in nibble r*4+c.
    localparam logic [63:0] KEYMAP = 64'hDF0E_C987_B654_A321;

    typedef enum logic [2:0] {
        IDLE,
        BOUNCE_IN,
        HOLD,
        BOUNCE_OUT,
        GAP
    } state_t;

    state_t      state;
    logic [15:0] cnt;
    logic [3:0]  key;
    logic        contact;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= 16'd0;
            key   <= 4'd0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // The done cycle is still IDLE but must not accept.
                    if (key_valid && !done) begin
                        key <= key_code;
`ifdef KEYPAD_EMU_BOUNCE_EN
                        state <= BOUNCE_IN;
                        cnt   <= BOUNCE_LEN;
`else
                        state <= HOLD;
                        cnt   <= HOLD_LEN;
`endif
                    end
                end
`ifdef KEYPAD_EMU_BOUNCE_EN
                BOUNCE_IN: begin
                    if (cnt == 16'd1) begin
                        state <= HOLD;
                        cnt   <= HOLD_LEN;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                BOUNCE_OUT: begin
                    if (cnt == 16'd1) begin
                        state <= GAP;
                        cnt   <= GAP_LEN;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
`endif
                HOLD: begin
                    if (cnt == 16'd1) begin
`ifdef KEYPAD_EMU_BOUNCE_EN
                        state <= BOUNCE_OUT;
                        cnt   <= BOUNCE_LEN;
`else
                        state <= GAP;
                        cnt   <= GAP_LEN;
`endif
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                GAP: begin
                    if (cnt == 16'd1) begin
                        state <= IDLE;
                        cnt   <= 16'd0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 16'd0;
                end
            endcase
        end
    end

`ifdef KEYPAD_EMU_BOUNCE_EN
    // x^8+x^6+x^5+x^4+1, free-running; bit 0 is the chattering contact.
    logic [7:0] lfsr;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    always_comb begin
        contact = 1'b0;
        case (state)
            BOUNCE_IN, BOUNCE_OUT: contact = lfsr[0];
            HOLD:                  contact = 1'b1;
            default:               contact = 1'b0;
        endcase
    end
`else
    logic [15:0] unused_bounce_len;
    assign unused_bounce_len = BOUNCE_LEN;

    always_comb begin
        contact = (state == HOLD);
    end
`endif

    always_comb begin
        col = 4'b0000;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (row[r] && contact && (KEYMAP[(r*4+c)*4 +: 4] == key)) begin
                    col[c] = 1'b1;
                end
            end
        end
    end

    assign key_ready = (state == IDLE) && !done;
    assign busy      = !key_ready;

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: cycle model with done scoreboard, table of key/row/col vectors, directed corner sequences.
module tb_keypad_emulator;

    localparam int H = 8;
    localparam int B = 4;
    localparam int G = 4;
`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam int OFF = B;
`else
    localparam int OFF = 0;
`endif
    localparam int LAT = 2*OFF + H + G + 1;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic [3:0] row = 4'd0;
    logic       key_ready;
    logic [3:0] col;
    logic       busy;
    logic       done;

    keypad_emulator #(.HOLD_CYCLES(H), .BOUNCE_CYCLES(B), .GAP_CYCLES(G)) dut (
        .clk(clk), .reset_n(reset_n), .key_valid(key_valid), .key_code(key_code),
        .key_ready(key_ready), .row(row), .col(col), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         busy_until = 0;
    int         acc_cyc = -1000;
    logic [3:0] acc_key = 4'd0;
    bit         active = 1'b0;
    bit         chk_en = 1'b0;
    int         done_q[$];

    typedef struct {
        logic [3:0] key;
        logic [3:0] rw;
        logic [3:0] exp;
    } vec_t;
    vec_t vecs[14];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Matrix position of a key as {row, col}.
    function automatic logic [3:0] key_pos(input logic [3:0] k);
        case (k)
            4'h1: return {2'd0, 2'd0};
            4'h2: return {2'd0, 2'd1};
            4'h3: return {2'd0, 2'd2};
            4'hA: return {2'd0, 2'd3};
            4'h4: return {2'd1, 2'd0};
            4'h5: return {2'd1, 2'd1};
            4'h6: return {2'd1, 2'd2};
            4'hB: return {2'd1, 2'd3};
            4'h7: return {2'd2, 2'd0};
            4'h8: return {2'd2, 2'd1};
            4'h9: return {2'd2, 2'd2};
            4'hC: return {2'd2, 2'd3};
            4'hE: return {2'd3, 2'd0};
            4'h0: return {2'd3, 2'd1};
            4'hF: return {2'd3, 2'd2};
            default: return {2'd3, 2'd3};
        endcase
    endfunction

    function automatic logic [3:0] exp_col(input logic [3:0] k, input logic [3:0] rw);
        logic [3:0] p;
        logic [3:0] res;
        p = key_pos(k);
        res = 4'b0000;
        if (rw[p[3:2]]) res[p[1:0]] = 1'b1;
        return res;
    endfunction

    // Model: acceptance and reset as seen at each rising edge.
    always @(posedge clk) begin
        if (!reset_n) begin
            done_q.delete();
            active = 1'b0;
            cyc++;
            busy_until = cyc;
        end else if (key_valid && cyc >= busy_until) begin
            cyc++;
            acc_cyc = cyc;
            acc_key = key_code;
            active = 1'b1;
            busy_until = cyc + LAT;
            done_q.push_back(cyc + LAT - 1);
        end else begin
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            int  k;
            bit  exp_rdy;
            bit  in_hold;
            bit  in_bounce;
            exp_rdy = (cyc >= busy_until);
            check("key_ready", key_ready, exp_rdy);
            check("busy", busy, !exp_rdy);
            k = cyc - acc_cyc;
            in_hold = active && (k >= OFF) && (k < OFF + H);
            in_bounce = active && ((k < OFF) || ((k >= OFF + H) && (k < 2*OFF + H)));
            if (!in_bounce) check("col_model", col, in_hold ? exp_col(acc_key, row) : 4'b0000);
            if (done) begin
                if (done_q.size() == 0) check("done_unexpected", done, 1'b0);
                else check("done_cycle", cyc, done_q.pop_front());
            end else if (done_q.size() > 0 && done_q[0] < cyc) begin
                check("done_missing", done, 1'b1);
                void'(done_q.pop_front());
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (cyc < busy_until && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 5000) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout: still busy at cycle %0d, required ready", cyc);
        end
    endtask

    task automatic press(input logic [3:0] k);
        wait_ready();
        key_code = k;
        key_valid = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0;
    endtask

    initial begin
        int e;
        int n;
        int ones;
        int toggles;
        logic prev;

        vecs[0]  = '{4'h2, 4'b0001, 4'b0010};
        vecs[1]  = '{4'h2, 4'b0010, 4'b0000};
        vecs[2]  = '{4'hD, 4'b1000, 4'b1000};
        vecs[3]  = '{4'hD, 4'b0111, 4'b0000};
        vecs[4]  = '{4'h0, 4'b1000, 4'b0010};
        vecs[5]  = '{4'h5, 4'b0010, 4'b0010};
        vecs[6]  = '{4'h5, 4'b1101, 4'b0000};
        vecs[7]  = '{4'h7, 4'b0100, 4'b0001};
        vecs[8]  = '{4'hA, 4'b0001, 4'b1000};
        vecs[9]  = '{4'hC, 4'b1111, 4'b1000};
        vecs[10] = '{4'hE, 4'b1000, 4'b0001};
        vecs[11] = '{4'h9, 4'b0100, 4'b0100};
        vecs[12] = '{4'hB, 4'b0000, 4'b0000};
        vecs[13] = '{4'h3, 4'b0001, 4'b0100};

        // Reset with every row driven: col must stay quiet.
        reset_n = 1'b0;
        row = 4'b1111;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        row = 4'b0000;

        foreach (vecs[i]) begin
            press(vecs[i].key);
            row = vecs[i].rw;
            repeat (OFF + 2) @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d_col", i), col, vecs[i].exp);
            @(posedge clk); #1;
            wait_ready();
            row = 4'b0000;
        end

        // Key D: count clean-contact cycles and done timing over one sequence.
        press(4'hD);
        e = cyc;
        row = 4'b1000;
        ones = 0;
        toggles = 0;
        prev = 1'b0;
        n = 0;
        @(negedge clk);
        while (!done && n < LAT + 10) begin
            if (col[3]) ones++;
            if (col[3] != prev) toggles++;
            prev = col[3];
            @(negedge clk);
            n++;
        end
        check("d_done_latency", cyc - e, LAT - 1);
        check("d_ready_in_done", key_ready, 1'b0);
`ifndef KEYPAD_EMU_BOUNCE_EN
        check("d_hold_cycles", ones, H);
        check("d_toggles", toggles, 2);
`endif
        @(negedge clk);
        check("d_ready_after_done", key_ready, 1'b1);
        row = 4'b0000;

        // Request for key 5 while key 0 is held must be dropped.
        press(4'h0);
        row = 4'b0010;
        repeat (OFF + 2) @(posedge clk);
        #1;
        key_code = 4'h5;
        key_valid = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0;
        @(negedge clk);
        check("busy_req_col", col, 4'b0000);
        check("busy_req_ready", key_ready, 1'b0);
        repeat (LAT + 4) @(posedge clk);
        #1;
        row = 4'b0000;

        // Request held high across the done cycle: two back-to-back presses of key 6.
        wait_ready();
        row = 4'b0010;
        key_code = 4'h6;
        key_valid = 1'b1;
        n = 0;
        e = acc_cyc;
        while (n < 3 * LAT && !(acc_cyc != e && cyc >= acc_cyc + LAT + 1)) begin
            @(posedge clk); #1;
            n++;
        end
        key_valid = 1'b0;
        wait_ready();
        row = 4'b0000;

        // Reset during HOLD of key F aborts the press.
        press(4'hF);
        row = 4'b1000;
        repeat (OFF + 2) @(posedge clk);
        @(negedge clk);
        check("f_hold_col", col, 4'b0100);
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("abort_col", col, 4'b0000);
        check("abort_ready", key_ready, 1'b1);
        check("abort_done", done, 1'b0);
        repeat (LAT + 5) @(posedge clk);
        #1;
        row = 4'b0000;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
